// File: rtl/usr_sequencer.sv
// Command sequencer that drives a 4-mode universal shift register.
// It runs LOAD, SHR, SHL and ROR commands through a four-state FSM with a shift down-counter.
module usr_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] usr_Q,
  output logic [1:0]       usr_S,
  output logic [WIDTH-1:0] usr_D,
  output logic             usr_SR,
  output logic             usr_SL,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       op;
  logic             fill;
  logic [WIDTH-1:0] data;
  logic             accept;

  // Only the LSB of the register contents feeds back (rotate right).
  logic unused_q;
  assign unused_q = ^usr_Q[WIDTH-1:1];

  assign accept = (state == IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= OP_LOAD;
      fill  <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op   <= cmd_op;
        fill <= cmd_fill;
        // usr_D keeps its last value unless a new LOAD arrives.
        if (cmd_op == OP_LOAD)
          data <= cmd_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD) begin
            state_nxt = LOAD;
          end else if (cmd_count == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
            cnt_nxt   = cmd_count;
          end
        end
      end
      LOAD:  state_nxt = DONE;
      SHIFT: begin
        // cnt is at least 1 here, so the decrement never wraps.
        cnt_nxt = cnt - 1'b1;
        if (cnt == {{(CNT_W-1){1'b0}}, 1'b1})
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    usr_S  = MODE_HOLD;
    usr_SR = 1'b0;
    usr_SL = 1'b0;
    case (state)
      LOAD: usr_S = MODE_LOAD;
      SHIFT: begin
        case (op)
          OP_SHR: begin
            usr_S  = MODE_SHR;
            usr_SR = fill;
          end
          OP_SHL: begin
            usr_S  = MODE_SHL;
            usr_SL = fill;
          end
          OP_ROR: begin
            usr_S  = MODE_SHR;
            usr_SR = usr_Q[0];
          end
          default: usr_S = MODE_HOLD;
        endcase
      end
      default: usr_S = MODE_HOLD;
    endcase
  end

  assign usr_D     = data;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench for usr_sequencer with a behavioural 4-bit universal shift register closing the usr_Q loop.
module tb_usr_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       cmd_fill;
  logic [3:0] q = 4'b0000;
  logic [1:0] usr_S;
  logic [3:0] usr_D;
  logic       usr_SR;
  logic       usr_SL;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  usr_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_count(cmd_count),
    .cmd_fill (cmd_fill),
    .usr_Q    (q),
    .usr_S    (usr_S),
    .usr_D    (usr_D),
    .usr_SR   (usr_SR),
    .usr_SL   (usr_SL),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Universal shift register: right shift fills MSB from SR, left shift fills LSB from SL.
  always @(posedge clk) begin
    case (usr_S)
      2'b01: q <= {usr_SR, q[3:1]};
      2'b10: q <= {q[2:0], usr_SL};
      2'b11: q <= usr_D;
      default: q <= q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [2:0] n, input logic f);
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = n;
    cmd_fill  = f;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  logic [3:0] exp_q [4];
  logic       exp_sr[4];

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    cmd_count = 3'd0;
    cmd_fill  = 1'b0;
    step();
    step();
    chk("rst_S",     usr_S, 2'b00);
    chk("rst_D",     usr_D, 4'h0);
    chk("rst_SR",    usr_SR, 1'b0);
    chk("rst_SL",    usr_SL, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);

    // LOAD 1010 accepted on the first edge after reset release
    reset = 1'b1;
    issue(2'b00, 4'b1010, 3'd0, 1'b0);
    chk("ld_S",     usr_S, 2'b11);
    chk("ld_D",     usr_D, 4'b1010);
    chk("ld_busy",  busy, 1'b1);
    chk("ld_ready", cmd_ready, 1'b0);
    chk("ld_done0", done, 1'b0);
    step();
    chk("ld_q",     q, 4'b1010);
    chk("ld_done",  done, 1'b1);
    chk("ld_S_dn",  usr_S, 2'b00);
    step();
    chk("ld_idle_done", done, 1'b0);
    chk("ld_idle_busy", busy, 1'b0);
    chk("ld_idle_D",    usr_D, 4'b1010);

    // SHR fill=1 count=4 from 0000
    issue(2'b00, 4'b0000, 3'd0, 1'b0);
    step();
    step();
    chk("shr_q0", q, 4'b0000);
    exp_q = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    issue(2'b01, 4'b0101, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("shr_S",    usr_S, 2'b01);
      chk("shr_SR",   usr_SR, 1'b1);
      chk("shr_SL",   usr_SL, 1'b0);
      chk("shr_done", done, 1'b0);
      step();
      chk("shr_q", q, exp_q[i]);
    end
    chk("shr_done_pulse", done, 1'b1);
    chk("shr_S_done",     usr_S, 2'b00);
    chk("shr_D_held",     usr_D, 4'b0000);
    step();
    chk("shr_ready", cmd_ready, 1'b1);

    // SHL fill=0 count=3 from 1111
    exp_q = '{4'b1110, 4'b1100, 4'b1000, 4'b1000};
    issue(2'b10, 4'h0, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("shl_S",  usr_S, 2'b10);
      chk("shl_SR", usr_SR, 1'b0);
      chk("shl_SL", usr_SL, 1'b0);
      step();
      chk("shl_q", q, exp_q[i]);
    end
    chk("shl_done", done, 1'b1);
    step();

    // LOAD 1011, ROR 1, then ROR 4
    issue(2'b00, 4'b1011, 3'd0, 1'b0);
    step();
    step();
    issue(2'b11, 4'h0, 3'd1, 1'b0);
    chk("ror1_S",  usr_S, 2'b01);
    chk("ror1_SR", usr_SR, 1'b1);
    step();
    chk("ror1_q",    q, 4'b1101);
    chk("ror1_done", done, 1'b1);
    step();
    exp_q  = '{4'b1110, 4'b0111, 4'b1011, 4'b1101};
    exp_sr = '{1'b1, 1'b0, 1'b1, 1'b1};
    issue(2'b11, 4'h0, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("ror4_S",  usr_S, 2'b01);
      chk("ror4_SR", usr_SR, exp_sr[i]);
      chk("ror4_SL", usr_SL, 1'b0);
      step();
      chk("ror4_q", q, exp_q[i]);
    end
    chk("ror4_done", done, 1'b1);
    step();

    // SHR count=0 with cmd_valid held high through DONE
    cmd_op    = 2'b01;
    cmd_count = 3'd0;
    cmd_fill  = 1'b1;
    cmd_data  = 4'b0110;
    cmd_valid = 1'b1;
    step();
    chk("z_done",  done, 1'b1);
    chk("z_S",     usr_S, 2'b00);
    chk("z_busy",  busy, 1'b1);
    chk("z_ready", cmd_ready, 1'b0);
    chk("z_q",     q, 4'b1101);
    cmd_op = 2'b00;
    step();
    chk("z_idle_ready", cmd_ready, 1'b1);
    chk("z_idle_done",  done, 1'b0);
    chk("z_idle_S",     usr_S, 2'b00);
    chk("z_q_hold",     q, 4'b1101);
    step();
    cmd_valid = 1'b0;
    chk("z_next_S", usr_S, 2'b11);
    chk("z_next_D", usr_D, 4'b0110);
    step();
    chk("z_next_q", q, 4'b0110);
    step();

    // Maximum count: SHR fill=0 count=7 stays in SHIFT for seven cycles
    issue(2'b01, 4'h0, 3'd7, 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk("max_S",    usr_S, 2'b01);
      chk("max_done", done, 1'b0);
      step();
    end
    chk("max_done_pulse", done, 1'b1);
    chk("max_q",          q, 4'b0000);
    step();
    chk("max_ready", cmd_ready, 1'b1);

    // Reset during the second cycle of SHR count=5
    issue(2'b01, 4'h0, 3'd5, 1'b1);
    step();
    chk("ab_q_mid", q, 4'b1000);
    chk("ab_S_mid", usr_S, 2'b01);
    #2;
    reset = 1'b0;
    #1;
    chk("ab_S",     usr_S, 2'b00);
    chk("ab_SR",    usr_SR, 1'b0);
    chk("ab_busy",  busy, 1'b0);
    chk("ab_ready", cmd_ready, 1'b1);
    chk("ab_done",  done, 1'b0);
    step();
    chk("ab_q_hold",    q, 4'b1000);
    chk("ab_done_rst",  done, 1'b0);
    reset = 1'b1;
    step();
    chk("ab_rel_ready", cmd_ready, 1'b1);
    chk("ab_rel_done",  done, 1'b0);
    chk("ab_rel_busy",  busy, 1'b0);
    chk("ab_rel_q",     q, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
